draw_image_blitter: RTL and testbench

//  Generic ROM-to-VGA image blitter; successor of the fixed full-screen draw_* blocks.

---
 rtl/draw_image_blitter.sv | 162 ++++++++++++++++
 tb/tb_draw_image_blitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_image_blitter.sv
// Generic ROM-to-VGA image blitter: scans an IMG_W x IMG_H ROM, emits one clipped pixel per cycle.
// Optional DRAW_BLIT_TRANSPARENCY_EN: pixels equal to KEY_COLOUR are not plotted.
module draw_image_blitter #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int COLOUR_W    = 9,
  parameter int ADDR_W      = 15,
  parameter int ROM_LATENCY = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          x_origin,
  input  logic [6:0]          y_origin,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

`ifdef DRAW_BLIT_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [7:0]        COL_LAST   = 8'(IMG_W - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(ROM_LATENCY);
  localparam logic [8:0]        SCR_W      = 9'(SCREEN_W);
  localparam logic [7:0]        SCR_H      = 8'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
  state_t state, state_n;

  logic [7:0] col;
  logic [6:0] row;
  logic [7:0] x_org;
  logic [6:0] y_org;
  logic [2:0] drain_cnt;
  logic       accept;
  logic       last_addr;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_addr = (rom_addr == ADDR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: begin
        busy = 1'b1;
        if (last_addr) state_n = S_DRAIN;
      end
      // DRAIN holds ROM_LATENCY+1 cycles so done rises one edge after the last plot slot
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      rom_addr  <= '0;
      x_org     <= '0;
      y_org     <= '0;
      drain_cnt <= '0;
    end else if (accept) begin
      col       <= '0;
      row       <= '0;
      rom_addr  <= '0;
      x_org     <= x_origin;
      y_org     <= y_origin;
      drain_cnt <= '0;
    end else if (state == S_FETCH) begin
      if (!last_addr) begin
        rom_addr <= rom_addr + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Coordinates of the issued address travel alongside the ROM read
  logic       pv   [ROM_LATENCY];
  logic [7:0] pcol [ROM_LATENCY];
  logic [6:0] prow [ROM_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        pv[i]   <= 1'b0;
        pcol[i] <= '0;
        prow[i] <= '0;
      end
    end else begin
      pv[0]   <= (state == S_FETCH);
      pcol[0] <= col;
      prow[0] <= row;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        pv[i]   <= pv[i-1];
        pcol[i] <= pcol[i-1];
        prow[i] <= prow[i-1];
      end
    end
  end

  logic [8:0] sx;
  logic [7:0] sy;
  logic       key_ok;
  logic       vis;

  assign sx     = {1'b0, x_org} + {1'b0, pcol[ROM_LATENCY-1]};
  assign sy     = {1'b0, y_org} + {1'b0, prow[ROM_LATENCY-1]};
  assign key_ok = !TRANSP_EN || (rom_q != KEY_COLOUR);
  assign vis    = pv[ROM_LATENCY-1] && (sx < SCR_W) && (sy < SCR_H) && key_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot   <= 1'b0;
      colour <= '0;
      x      <= '0;
      y      <= '0;
    end else begin
      plot   <= vis;
      colour <= rom_q;
      if (vis) begin
        x <= sx[7:0];
        y <= sy[6:0];
      end
    end
  end

endmodule

// File: tb/tb_draw_image_blitter.sv
// Bench for draw_image_blitter: three parameterisations, table vectors, random blits, reset/start corners.
module tb_draw_image_blitter;

  localparam int NI = 3;
`ifdef DRAW_BLIT_TRANSPARENCY_EN
  localparam bit TB_TR = 1'b1;
`else
  localparam bit TB_TR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rom_mode = 0;

  logic        start_i [NI];
  logic [7:0]  xo_i    [NI];
  logic [6:0]  yo_i    [NI];
  logic [14:0] addr_o  [NI];
  logic [7:0]  x_o     [NI];
  logic [6:0]  y_o     [NI];
  logic [8:0]  col_o   [NI];
  logic        plot_o  [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int iw(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 160 : 1);
  endfunction
  function automatic int ih(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 120 : 3);
  endfunction
  function automatic int il(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  // Image content: address itself, or every odd word replaced by the key colour
  function automatic logic [8:0] rom_fn(input int a);
    if (rom_mode != 0 && (a % 2) == 1) return 9'h1FF;
    return 9'(a % 512);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 160 : 1);
    localparam int H = (g == 0) ? 2 : ((g == 1) ? 120 : 3);
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    logic [8:0] rpipe [L];

    always @(posedge clk) begin
      rpipe[0] <= rom_fn(int'(addr_o[g]));
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end

    draw_image_blitter #(
      .IMG_W(W), .IMG_H(H), .ROM_LATENCY(L), .KEY_COLOUR(9'h1FF)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_i[g]),
      .x_origin(xo_i[g]), .y_origin(yo_i[g]),
      .rom_addr(addr_o[g]), .rom_q(rpipe[L-1]),
      .x(x_o[g]), .y(y_o[g]), .colour(col_o[g]),
      .plot(plot_o[g]), .busy(busy_o[g]), .done(done_o[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } pix_t;
  pix_t exp_q[$];

  // Reference: walk the image row-major, keep on-screen (and non-key) pixels
  task automatic build_exp(input int inst, input int xo, input int yo, input int n0);
    int a, sx, sy, cl;
    exp_q.delete();
    for (int r = 0; r < ih(inst); r++) begin
      for (int c = 0; c < iw(inst); c++) begin
        a  = r * iw(inst) + c;
        sx = xo + c;
        sy = yo + r;
        cl = int'(rom_fn(a));
        if (sx < 160 && sy < 120 && !(TB_TR && cl == 511))
          exp_q.push_back('{n0 + 1 + il(inst) + a, sx, sy, cl});
      end
    end
  endtask

  task automatic run_blit(input int inst, input int xo, input int yo,
                          input int pulse_at, output int nplots);
    int n0, bound, done_cyc, total, lx, ly, bad;
    bit hold_bad, have, first_bad_shown;
    pix_t e;
    total = iw(inst) * ih(inst);
    nplots = 0; done_cyc = -1; hold_bad = 0; have = 0; bad = 0; first_bad_shown = 0;
    lx = 0; ly = 0;
    @(negedge clk);
    xo_i[inst] = 8'(xo); yo_i[inst] = 7'(yo); start_i[inst] = 1'b1;
    @(posedge clk); #1;
    n0 = cyc;
    build_exp(inst, xo, yo, n0);
    @(negedge clk);
    start_i[inst] = 1'b0;
    xo_i[inst] = 8'($urandom); yo_i[inst] = 7'($urandom);
    chk("busy_after_start", int'(busy_o[inst]), 1);
    chk("done_after_start", int'(done_o[inst]), 0);
    bound = total + il(inst) + 20;
    for (int k = 0; k < bound && done_cyc < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (plot_o[inst]) begin
        nplots++;
        if (exp_q.size() == 0) begin
          bad++;
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || int'(x_o[inst]) != e.x || int'(y_o[inst]) != e.y ||
              int'(col_o[inst]) != e.c) begin
            bad++;
            if (!first_bad_shown)
              $display("first bad pixel: got cyc=%0d (%0d,%0d) c=%0d, wanted cyc=%0d (%0d,%0d) c=%0d",
                       cyc, x_o[inst], y_o[inst], col_o[inst], e.cyc, e.x, e.y, e.c);
            first_bad_shown = 1;
          end
        end
        lx = int'(x_o[inst]); ly = int'(y_o[inst]); have = 1;
      end else if (have && (int'(x_o[inst]) != lx || int'(y_o[inst]) != ly)) begin
        hold_bad = 1;
      end
      if (done_o[inst]) done_cyc = cyc;
      if (pulse_at >= 0 && k == pulse_at) begin
        start_i[inst] = 1'b1; xo_i[inst] = 8'd50; yo_i[inst] = 7'd50;
      end else begin
        start_i[inst] = 1'b0;
      end
    end
    start_i[inst] = 1'b0;
    chk("pixel_mismatches", bad, 0);
    chk("missing_plots", exp_q.size(), 0);
    chk("xy_hold", int'(hold_bad), 0);
    chk("done_cycle", done_cyc, n0 + total + il(inst) + 1);
    chk("busy_in_done", int'(busy_o[inst]), 0);
  endtask

  typedef struct {
    int inst;
    int xo;
    int yo;
    int mode;
    int pulse;
    int exp;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int   np;
    int   inst;

    tbl[0] = '{0, 10, 5, 0, -1, 8};
    tbl[1] = '{0, 158, 119, 0, -1, 2};
    tbl[2] = '{0, 20, 30, 0, 3, 8};
    tbl[3] = '{0, 50, 50, 0, -1, 8};
    tbl[4] = '{0, 10, 5, 0, 7, 8};
    tbl[5] = '{0, 10, 5, 0, 9, 8};
    tbl[6] = '{0, 0, 0, 1, -1, TB_TR ? 4 : 8};
    tbl[7] = '{2, 159, 118, 0, -1, 2};
    tbl[8] = '{2, 5, 5, 1, -1, TB_TR ? 2 : 3};
    tbl[9] = '{1, 0, 0, 0, -1, TB_TR ? 19163 : 19200};

    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_i[i] = 1'b0; xo_i[i] = '0; yo_i[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_plot", int'(plot_o[i]), 0);
      chk("rst_busy", int'(busy_o[i]), 0);
      chk("rst_done", int'(done_o[i]), 0);
      chk("rst_x", int'(x_o[i]), 0);
      chk("rst_y", int'(y_o[i]), 0);
      chk("rst_colour", int'(col_o[i]), 0);
      chk("rst_addr", int'(addr_o[i]), 0);
    end
    reset = 1'b0;

    foreach (tbl[v]) begin
      rom_mode = tbl[v].mode;
      run_blit(tbl[v].inst, tbl[v].xo, tbl[v].yo, tbl[v].pulse, np);
      chk("table_plot_count", np, tbl[v].exp);
    end

    // Reset in the middle of FETCH, then a clean restart
    rom_mode = 0;
    @(negedge clk);
    xo_i[0] = 8'd10; yo_i[0] = 7'd5; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("plot_before_reset", int'(plot_o[0]), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_plot", int'(plot_o[0]), 0);
    chk("async_rst_busy", int'(busy_o[0]), 0);
    chk("async_rst_done", int'(done_o[0]), 0);
    chk("async_rst_addr", int'(addr_o[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    run_blit(0, 10, 5, -1, np);
    chk("restart_plot_count", np, 8);

    for (int r = 0; r < 12; r++) begin
      inst = ($urandom % 2 == 0) ? 0 : 2;
      rom_mode = int'($urandom % 2);
      run_blit(inst, int'($urandom % 256), int'($urandom % 128),
               ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, 6)), np);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
